// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared fighter definitions: attack phase codes and hitbox size
//   phase_e      : 2-bit attack phase code driven to the renderer
//   HITBOX_WIDTH : width of the attack hitbox in pixels
//   HITBOX_HEIGHT: height of the attack hitbox in pixels
package fighter_pkg;

    typedef enum logic [1:0] {
        PH_IDLE     = 2'b00,
        PH_STARTUP  = 2'b01,
        PH_ACTIVE   = 2'b10,
        PH_RECOVERY = 2'b11
    } phase_e;

    localparam int HITBOX_WIDTH  = 32;
    localparam int HITBOX_HEIGHT = 8;

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - combinational inclusive axis-aligned box overlap test
//   en                                  : in  gate; low forces no overlap (empty box)
//   a_left/a_right/a_top/a_bottom       : in  inclusive edges of box A
//   b_left/b_right/b_top/b_bottom       : in  inclusive edges of box B
//   hit                                 : out boxes share at least one pixel
module box_overlap #(
    parameter int W = 11
) (
    input  logic         en,
    input  logic [W-1:0] a_left,
    input  logic [W-1:0] a_right,
    input  logic [W-1:0] a_top,
    input  logic [W-1:0] a_bottom,
    input  logic [W-1:0] b_left,
    input  logic [W-1:0] b_right,
    input  logic [W-1:0] b_top,
    input  logic [W-1:0] b_bottom,
    output logic         hit
);

    assign hit = en
               && (a_left <= b_right) && (b_left <= a_right)
               && (a_top <= b_bottom) && (b_top <= a_bottom);

endmodule

// File: rtl/attack_phase_controller.sv
// rtl/attack_phase_controller.sv - frame-counted attack sequencer with single-hit detection
//   clk, rst_n                     : in  clock, async active-low reset
//   frame_tick                     : in  one-cycle pulse per video frame
//   attack_btn                     : in  raw asynchronous attack button
//   char_x/y_pos, char_width/height: in  own character box (10 bit)
//   opp_x/y_pos, opp_width/height  : in  opponent hurtbox (10 bit)
//   attack_phase_out               : out 00 idle, 01 startup, 10 active, 11 recovery
//   attack_busy_out                : out phase is not idle
//   hit_pulse_out                  : out one-cycle pulse on the single hit of an attack
module attack_phase_controller
    import fighter_pkg::*;
#(
    parameter int STARTUP_FRAMES  = 5,
    parameter int ACTIVE_FRAMES   = 2,
    parameter int RECOVERY_FRAMES = 16,
    parameter int FCNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       attack_btn,
    input  logic [9:0] char_x_pos,
    input  logic [9:0] char_y_pos,
    input  logic [9:0] char_width,
    input  logic [9:0] char_height,
    input  logic [9:0] opp_x_pos,
    input  logic [9:0] opp_y_pos,
    input  logic [9:0] opp_width,
    input  logic [9:0] opp_height,
    output logic [1:0] attack_phase_out,
    output logic       attack_busy_out,
    output logic       hit_pulse_out
);

    localparam logic [FCNT_W-1:0] ST_LOAD = FCNT_W'(STARTUP_FRAMES - 1);
    localparam logic [FCNT_W-1:0] AC_LOAD = FCNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] RC_LOAD = FCNT_W'(RECOVERY_FRAMES - 1);

    phase_e              state_q, state_d;
    logic [FCNT_W-1:0]   cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                hit_done_q, hit_done_d;
    logic                hit_q, hit_d;
    logic                btn_s1_q, btn_s2_q, btn_s3_q;
    logic                press;
    logic                overlap;

    // Hitbox in 11 bits so a box hanging past x=1023 is not folded back to the left.
    logic [10:0] hb_left, hb_right, hb_mid, hb_top, hb_bottom;
    logic [10:0] op_right, op_bottom;

    assign hb_left   = {1'b0, char_x_pos} + {1'b0, char_width};
    assign hb_right  = hb_left + 11'(HITBOX_WIDTH - 1);
    assign hb_mid    = {1'b0, char_y_pos} + ({1'b0, char_height} >> 1);
    // Clamp at the top of the screen instead of wrapping to a huge row.
    assign hb_top    = (hb_mid < 11'(HITBOX_HEIGHT / 2)) ? 11'd0
                                                          : hb_mid - 11'(HITBOX_HEIGHT / 2);
    assign hb_bottom = hb_top + 11'(HITBOX_HEIGHT - 1);
    assign op_right  = {1'b0, opp_x_pos} + {1'b0, opp_width} - 11'd1;
    assign op_bottom = {1'b0, opp_y_pos} + {1'b0, opp_height} - 11'd1;

    box_overlap #(.W(11)) u_hit_test (
        .en       ((opp_width != 10'd0) && (opp_height != 10'd0)),
        .a_left   (hb_left),
        .a_right  (hb_right),
        .a_top    (hb_top),
        .a_bottom (hb_bottom),
        .b_left   ({1'b0, opp_x_pos}),
        .b_right  (op_right),
        .b_top    ({1'b0, opp_y_pos}),
        .b_bottom (op_bottom),
        .hit      (overlap)
    );

    assign press = btn_s2_q & ~btn_s3_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        hit_done_d = hit_done_q;
        hit_d      = 1'b0;

        // Presses during an attack are dropped, never queued.
        if (press && state_q == PH_IDLE) begin
            pending_d = 1'b1;
        end

        if (frame_tick) begin
            case (state_q)
                PH_IDLE: begin
                    if (pending_q || press) begin
                        state_d    = PH_STARTUP;
                        cnt_d      = ST_LOAD;
                        pending_d  = 1'b0;
                        hit_done_d = 1'b0;
                    end
                end
                PH_STARTUP: begin
                    if (cnt_q == '0) begin
                        state_d = PH_ACTIVE;
                        cnt_d   = AC_LOAD;
                    end else begin
                        cnt_d = cnt_q - FCNT_W'(1);
                    end
                end
                PH_ACTIVE: begin
                    if (cnt_q == '0) begin
                        state_d = PH_RECOVERY;
                        cnt_d   = RC_LOAD;
                    end else begin
                        cnt_d = cnt_q - FCNT_W'(1);
                    end
                end
                PH_RECOVERY: begin
                    if (cnt_q == '0) begin
                        state_d = PH_IDLE;
                    end else begin
                        cnt_d = cnt_q - FCNT_W'(1);
                    end
                end
                default: begin
                    state_d = PH_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Uses the current phase, so overlap on the last ACTIVE cycle still counts.
        if (state_q == PH_ACTIVE && overlap && !hit_done_q) begin
            hit_done_d = 1'b1;
            hit_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PH_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            hit_done_q <= 1'b0;
            hit_q      <= 1'b0;
            // Synchroniser resets high so a button held through reset is not a press.
            btn_s1_q   <= 1'b1;
            btn_s2_q   <= 1'b1;
            btn_s3_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            hit_done_q <= hit_done_d;
            hit_q      <= hit_d;
            btn_s1_q   <= attack_btn;
            btn_s2_q   <= btn_s1_q;
            btn_s3_q   <= btn_s2_q;
        end
    end

    assign attack_phase_out = state_q;
    assign attack_busy_out  = (state_q != PH_IDLE);
    assign hit_pulse_out    = hit_q;

endmodule

// File: tb/tb_attack_phase_controller.sv
// tb/tb_attack_phase_controller.sv - self-checking bench for attack_phase_controller
module tb_attack_phase_controller;

    localparam int S   = 5;
    localparam int A   = 2;
    localparam int R   = 16;
    localparam int GAP = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       attack_btn;
    logic [9:0] char_x_pos, char_y_pos, char_width, char_height;
    logic [9:0] opp_x_pos, opp_y_pos, opp_width, opp_height;
    logic [1:0] attack_phase_out;
    logic       attack_busy_out;
    logic       hit_pulse_out;

    int errors = 0;
    int checks = 0;
    int hits   = 0;

    typedef struct {
        string      tag;
        logic [1:0] phase;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    attack_phase_controller #(
        .STARTUP_FRAMES  (S),
        .ACTIVE_FRAMES   (A),
        .RECOVERY_FRAMES (R),
        .FCNT_W          (5)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_tick       (frame_tick),
        .attack_btn       (attack_btn),
        .char_x_pos       (char_x_pos),
        .char_y_pos       (char_y_pos),
        .char_width       (char_width),
        .char_height      (char_height),
        .opp_x_pos        (opp_x_pos),
        .opp_y_pos        (opp_y_pos),
        .opp_width        (opp_width),
        .opp_height       (opp_height),
        .attack_phase_out (attack_phase_out),
        .attack_busy_out  (attack_busy_out),
        .hit_pulse_out    (hit_pulse_out)
    );

    always @(negedge clk) begin
        if (hit_pulse_out === 1'b1) hits++;
    end

    // Phase expected after the k-th tick counted from the tick that starts the attack.
    function automatic logic [1:0] model_phase(input int k);
        if (k < 1)         return 2'b00;
        if (k <= S)        return 2'b01;
        if (k <= S + A)    return 2'b10;
        if (k <= S + A + R) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int model_hit(input int cx, cy, cw, ch, ox, oy, ow, oh);
        int l, r, t, b;
        l = cx + cw;
        r = l + 31;
        t = cy + ch / 2 - 4;
        if (t < 0) t = 0;
        b = t + 7;
        if (ow == 0 || oh == 0) return 0;
        if (l <= ox + ow - 1 && ox <= r && t <= oy + oh - 1 && oy <= b) return 1;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int k);
        exp_t e;
        e.tag   = tag;
        e.phase = model_phase(k);
        e.busy  = (model_phase(k) != 2'b00);
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_phase"}, {30'd0, attack_phase_out}, {30'd0, e.phase});
        check({e.tag, "_busy"}, {31'd0, attack_busy_out}, {31'd0, e.busy});
    endtask

    task automatic tick_step(input string tag, input int k);
        push_exp($sformatf("%s_k%0d", tag, k), k);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        pop_check();
        repeat (GAP - 2) @(negedge clk);
    endtask

    task automatic press_btn();
        @(negedge clk) attack_btn = 1'b1;
        repeat (4) @(negedge clk);
        attack_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_boxes(input int cx, cy, cw, ch, ox, oy, ow, oh);
        char_x_pos  = 10'(cx); char_y_pos = 10'(cy);
        char_width  = 10'(cw); char_height = 10'(ch);
        opp_x_pos   = 10'(ox); opp_y_pos  = 10'(oy);
        opp_width   = 10'(ow); opp_height = 10'(oh);
    endtask

    task automatic hit_attack(input string tag, input int cx, cy, cw, ch, ox, oy, ow, oh);
        set_boxes(cx, cy, cw, ch, ox, oy, ow, oh);
        hits = 0;
        press_btn();
        for (int k = 1; k <= S + A + R + 1; k++) tick_step(tag, k);
        check({tag, "_hits"}, hits, model_hit(cx, cy, cw, ch, ox, oy, ow, oh));
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        attack_btn = 1'b0;
        set_boxes(100, 200, 32, 64, 600, 200, 20, 40);
        repeat (3) @(negedge clk);
        check("reset_phase", {30'd0, attack_phase_out}, 32'd0);
        check("reset_busy", {31'd0, attack_busy_out}, 32'd0);
        check("reset_hit", {31'd0, hit_pulse_out}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tick_step("no_press", 0);

        // Basic full sequence
        hits = 0;
        press_btn();
        for (int k = 1; k <= S + A + R + 1; k++) tick_step("basic", k);
        check("basic_hits", hits, 0);

        // Presses during startup and recovery are dropped
        press_btn();
        for (int k = 1; k <= S + A + R + 1; k++) begin
            tick_step("busy", k);
            if (k == 3 || k == 12) press_btn();
        end
        tick_step("busy_nobuf", S + A + R + 2);
        press_btn();
        for (int k = 1; k <= S + A + R + 1; k++) tick_step("again", k);

        // Hit geometry cases
        hit_attack("hit",      100, 200, 32, 64, 140, 220, 20, 40);
        hit_attack("miss170",  100, 200, 32, 64, 170, 220, 20, 40);
        hit_attack("zero_w",   100, 200, 32, 64, 140, 220,  0, 40);
        hit_attack("ovf_hit", 1000, 200, 20, 64, 1015, 220, 10, 40);
        hit_attack("ovf_miss",1000, 200, 20, 64, 1015, 220,  5, 40);

        // Reset in ACTIVE with button held through release
        set_boxes(100, 200, 32, 64, 140, 220, 20, 40);
        press_btn();
        for (int k = 1; k <= S + 1; k++) tick_step("mid", k);
        #2;
        attack_btn = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_phase", {30'd0, attack_phase_out}, 32'd0);
        check("mid_rst_busy", {31'd0, attack_busy_out}, 32'd0);
        check("mid_rst_hit", {31'd0, hit_pulse_out}, 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tick_step("held", 0);
        tick_step("held", 0);
        attack_btn = 1'b0;
        repeat (3) @(negedge clk);
        hit_attack("after_rst", 100, 200, 32, 64, 140, 220, 20, 40);

        // Press edge coincides with frame_tick
        set_boxes(100, 200, 32, 64, 600, 200, 20, 40);
        @(negedge clk) attack_btn = 1'b1;
        @(negedge clk);
        @(negedge clk) frame_tick = 1'b1;
        push_exp("ptick_k1", 1);
        @(negedge clk) frame_tick = 1'b0;
        pop_check();
        attack_btn = 1'b0;
        repeat (GAP) @(negedge clk);
        for (int k = 2; k <= S + A + R + 2; k++) tick_step("ptick", k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
